// File: rtl/fetch_issue.sv
// fetch_issue: instruction fetch/issue register between ProgCtr and the
// decoder/ALU. Captures the ROM word at the current PC, decodes branch and
// halt opcodes, drives the branch target back to ProgCtr from a 16-entry
// offset table, bubbles one cycle after a taken branch and latches a sticky
// Done on halt. The offset table is written by the host while Start is high.
module fetch_issue #(
    parameter int L = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [L-1:0] PcIn,
    input  logic [W-1:0] InstIn,
    input  logic         ALUFlag,
    input  logic         LutWe,
    input  logic [3:0]   LutAddr,
    input  logic [L-1:0] LutData,
    output logic [W-1:0] Inst,
    output logic [L-1:0] InstPc,
    output logic         InstValid,
    output logic         BranchRel,
    output logic [L-1:0] Target,
    output logic         Done
);

    localparam logic [3:0] OP_BRANCH = 4'b1111;
    localparam logic [3:0] OP_HALT   = 4'b1110;

    logic [W-1:0] inst_q, inst_d;
    logic [L-1:0] inst_pc_q, inst_pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic         done_q, done_d;
    logic [L-1:0] lut_q [16];

    logic [3:0]   opcode;
    logic [3:0]   lut_idx;
    logic         is_br;
    logic         is_halt;
    logic         taken;

    // Decode straight off the issue register so BranchRel/Target line up with Inst.
    always_comb begin
        opcode  = inst_q[W-1:W-4];
        lut_idx = inst_q[3:0];
        is_br   = inst_valid_q && (opcode == OP_BRANCH);
        is_halt = inst_valid_q && (opcode == OP_HALT);
        taken   = is_br && ALUFlag;
    end

    // ProgCtr already holds InstPc+1, so the offset is reduced by one; wraps mod 2^L.
    assign Target    = lut_q[lut_idx] - {{(L-1){1'b0}}, 1'b1};
    assign BranchRel = is_br;

    // Next-state for the issue register, highest priority first.
    always_comb begin
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        done_d       = done_q;
        if (Reset) begin
            inst_d       = '0;
            inst_pc_d    = '0;
            inst_valid_d = 1'b0;
            done_d       = 1'b0;
        end else if (Start) begin
            inst_valid_d = 1'b0;
            done_d       = 1'b0;
        end else if (done_q) begin
            inst_valid_d = 1'b0;
        end else if (is_halt) begin
            // The word fetched behind the halt is dropped.
            done_d       = 1'b1;
            inst_valid_d = 1'b0;
        end else if (taken) begin
            // One-cycle bubble: the wrong-path word at InstPc+1 is dropped.
            inst_valid_d = 1'b0;
        end else begin
            inst_d       = InstIn;
            inst_pc_d    = PcIn;
            inst_valid_d = 1'b1;
        end
    end

    // Issue register state update.
    always_ff @(posedge Clk) begin
        inst_q       <= inst_d;
        inst_pc_q    <= inst_pc_d;
        inst_valid_q <= inst_valid_d;
        done_q       <= done_d;
    end

    // Branch-offset table: cleared by Reset, host-written only while Start is high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) begin
                lut_q[i] <= '0;
            end
        end else if (Start && LutWe) begin
            lut_q[LutAddr] <= LutData;
        end
    end

    assign Inst      = inst_q;
    assign InstPc    = inst_pc_q;
    assign InstValid = inst_valid_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_fetch_issue.sv
// Table-driven bench for fetch_issue with a small ProgCtr/ROM environment.
module tb_fetch_issue;

    localparam int L = 10;
    localparam int W = 9;

    logic         Clk = 1'b0;
    logic         Reset, Start, ALUFlag, LutWe;
    logic [3:0]   LutAddr;
    logic [L-1:0] LutData;
    logic [L-1:0] PcIn;
    logic [W-1:0] InstIn;
    logic [W-1:0] Inst;
    logic [L-1:0] InstPc;
    logic         InstValid, BranchRel, Done;
    logic [L-1:0] Target;

    logic [W-1:0] rom [0:1023];
    logic [L-1:0] pc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         rst;
        logic         start;
        logic         alu;
        logic         we;
        logic [3:0]   addr;
        logic [L-1:0] data;
        logic         e_valid;
        logic [L-1:0] e_pc;
        logic [W-1:0] e_inst;
        logic         e_br;
        logic [L-1:0] e_tgt;
        logic         e_done;
    } vec_t;

    vec_t tbl [0:32];

    fetch_issue #(.L(L), .W(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .PcIn(PcIn), .InstIn(InstIn),
        .ALUFlag(ALUFlag), .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
        .Inst(Inst), .InstPc(InstPc), .InstValid(InstValid),
        .BranchRel(BranchRel), .Target(Target), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Program counter model: held at 0 by Reset/Start, relative branch otherwise.
    always_ff @(posedge Clk) begin
        if (Reset || Start)
            pc <= '0;
        else if (BranchRel && ALUFlag)
            pc <= pc + Target;
        else
            pc <= pc + 1'b1;
    end

    assign PcIn   = pc;
    assign InstIn = rom[pc];

    function automatic vec_t v(input logic r, s, a, we, input logic [3:0] ad,
                               input logic [L-1:0] d, input logic ev,
                               input logic [L-1:0] ipc, input logic [W-1:0] ins,
                               input logic br, input logic [L-1:0] tg, input logic dn);
        vec_t t;
        t.rst = r; t.start = s; t.alu = a; t.we = we; t.addr = ad; t.data = d;
        t.e_valid = ev; t.e_pc = ipc; t.e_inst = ins; t.e_br = br; t.e_tgt = tg; t.e_done = dn;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [vec %0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input int idx);
        vec_t t;
        t = tbl[idx];
        Reset   = t.rst;
        Start   = t.start;
        ALUFlag = t.alu;
        LutWe   = t.we;
        LutAddr = t.addr;
        LutData = t.data;
        @(posedge Clk);
        #1;
        chk("InstValid", idx, 32'(InstValid), 32'(t.e_valid));
        chk("BranchRel", idx, 32'(BranchRel), 32'(t.e_br));
        chk("Done", idx, 32'(Done), 32'(t.e_done));
        if (t.e_valid || t.rst) begin
            chk("InstPc", idx, 32'(InstPc), 32'(t.e_pc));
            chk("Inst", idx, 32'(Inst), 32'(t.e_inst));
        end
        if (t.e_br)
            chk("Target", idx, 32'(Target), 32'(t.e_tgt));
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            apply(i);
    endtask

    initial begin
        //          rst st alu we addr data    valid pc      inst    br tgt     done
        // Sequential issue, halt, Start clears Done, LUT loads
        tbl[0]  = v(0, 0, 0, 0, 4'd0, 10'h000, 1, 10'd0, 9'h005, 0, 10'h000, 0);
        tbl[1]  = v(0, 0, 0, 0, 4'd0, 10'h000, 1, 10'd1, 9'h006, 0, 10'h000, 0);
        tbl[2]  = v(0, 0, 0, 0, 4'd0, 10'h000, 1, 10'd2, 9'h1C0, 0, 10'h000, 0);
        tbl[3]  = v(0, 0, 0, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 1);
        tbl[4]  = v(0, 0, 0, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 1);
        tbl[5]  = v(0, 0, 1, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 1);
        tbl[6]  = v(0, 1, 0, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        tbl[7]  = v(0, 1, 0, 1, 4'd3, 10'd4,   0, 10'd0, 9'h000, 0, 10'h000, 0);
        tbl[8]  = v(0, 1, 0, 1, 4'd1, 10'h3FE, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        tbl[9]  = v(0, 1, 0, 1, 4'd2, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        // Forward taken branch (bubble), then Start kill, then not-taken branch
        tbl[10] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd0, 9'h1E3, 1, 10'h003, 0);
        tbl[11] = v(0, 0, 1, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        tbl[12] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd4, 9'h055, 0, 10'h000, 0);
        tbl[13] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd5, 9'h0BB, 0, 10'h000, 0);
        tbl[14] = v(0, 1, 0, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        tbl[15] = v(0, 0, 0, 0, 4'd0, 10'h000, 1, 10'd0, 9'h1E3, 1, 10'h003, 0);
        tbl[16] = v(0, 0, 0, 0, 4'd0, 10'h000, 1, 10'd1, 9'h0AA, 0, 10'h000, 0);
        tbl[17] = v(0, 0, 0, 0, 4'd0, 10'h000, 1, 10'd2, 9'h0AB, 0, 10'h000, 0);
        tbl[18] = v(0, 1, 0, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        // Backward branch at PC 5 with offset -2; LutWe with Start low is ignored
        tbl[19] = v(0, 0, 1, 1, 4'd1, 10'h000, 1, 10'd0, 9'h010, 0, 10'h000, 0);
        tbl[20] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd1, 9'h011, 0, 10'h000, 0);
        tbl[21] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd2, 9'h012, 0, 10'h000, 0);
        tbl[22] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd3, 9'h013, 0, 10'h000, 0);
        tbl[23] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd4, 9'h014, 0, 10'h000, 0);
        tbl[24] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd5, 9'h1E1, 1, 10'h3FD, 0);
        tbl[25] = v(0, 0, 1, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        tbl[26] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd3, 9'h013, 0, 10'h000, 0);
        tbl[27] = v(0, 1, 0, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        // Zero offset re-executes the branch; Reset beats a pending taken branch
        tbl[28] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd0, 9'h1E2, 1, 10'h3FF, 0);
        tbl[29] = v(0, 0, 1, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        tbl[30] = v(0, 0, 1, 0, 4'd0, 10'h000, 1, 10'd0, 9'h1E2, 1, 10'h3FF, 0);
        tbl[31] = v(1, 0, 1, 0, 4'd0, 10'h000, 0, 10'd0, 9'h000, 0, 10'h000, 0);
        // After Reset, Lut[3] (was 4) reads 0, so Target = 0 - 1
        tbl[32] = v(0, 0, 0, 0, 4'd0, 10'h000, 1, 10'd0, 9'h1E3, 1, 10'h3FF, 0);

        for (int i = 0; i < 1024; i++)
            rom[i] = '0;
        rom[0] = 9'h005; rom[1] = 9'h006; rom[2] = 9'h1C0; rom[3] = 9'h007;

        // Hand sequence: reset state
        Reset = 1'b1; Start = 1'b0; ALUFlag = 1'b0; LutWe = 1'b0;
        LutAddr = 4'd0; LutData = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_Inst", -1, 32'(Inst), 32'h0);
        chk("rst_InstPc", -1, 32'(InstPc), 32'h0);
        chk("rst_InstValid", -1, 32'(InstValid), 32'h0);
        chk("rst_Done", -1, 32'(Done), 32'h0);
        chk("rst_BranchRel", -1, 32'(BranchRel), 32'h0);

        run(0, 9);

        // Branch program, loaded while Start is high
        rom[0] = 9'h1E3; rom[1] = 9'h0AA; rom[2] = 9'h0AB; rom[3] = 9'h0AC;
        rom[4] = 9'h055; rom[5] = 9'h0BB;
        run(10, 18);

        rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h012; rom[3] = 9'h013;
        rom[4] = 9'h014; rom[5] = 9'h1E1; rom[6] = 9'h016;
        run(19, 27);

        rom[0] = 9'h1E2;
        run(28, 31);

        // Hand sequence: with Reset still high, swap in a branch using index 3
        rom[0] = 9'h1E3;
        run(32, 32);

        // Hand sequence: halt reached via taken branch, Done holds, Start clears it
        Start = 1'b1; LutWe = 1'b1; LutAddr = 4'd5; LutData = 10'd3;
        rom[0] = 9'h1E5; rom[1] = 9'h0CC; rom[3] = 9'h1C7; rom[4] = 9'h0DD;
        @(posedge Clk); #1;
        Start = 1'b0; LutWe = 1'b0; ALUFlag = 1'b1;
        @(posedge Clk); #1;
        chk("h_br", 33, 32'(BranchRel), 32'h1);
        chk("h_tgt", 33, 32'(Target), 32'h002);
        @(posedge Clk); #1;
        chk("h_bubble", 34, 32'(InstValid), 32'h0);
        @(posedge Clk); #1;
        chk("h_pc", 35, 32'(InstPc), 32'h3);
        chk("h_inst", 35, 32'(Inst), 32'h1C7);
        chk("h_done0", 35, 32'(Done), 32'h0);
        @(posedge Clk); #1;
        chk("h_done1", 36, 32'(Done), 32'h1);
        chk("h_valid", 36, 32'(InstValid), 32'h0);
        repeat (3) @(posedge Clk);
        #1;
        chk("h_done_hold", 37, 32'(Done), 32'h1);
        chk("h_valid_hold", 37, 32'(InstValid), 32'h0);
        Start = 1'b1;
        @(posedge Clk); #1;
        chk("h_done_clr", 38, 32'(Done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_issue.md
# fetch_issue

Instruction fetch/issue register between `ProgCtr` and the decoder/ALU.
- Each cycle it captures the instruction word read combinationally from instruction ROM at the current PC, together with that PC.
- It drives `BranchRel` and `Target` back to `ProgCtr` from a 16-entry branch-offset lookup table.
- It inserts a one-cycle bubble after a taken branch, and raises `Done` on a halt instruction.
- The LUT is loaded by the host while `Start` is high.

## Interface
Parameters:
- `L`, default 10: PC / target width; must equal `ProgCtr` L.
- `W`, default 9: instruction width. Opcode is `Inst[W-1:W-4]`; LUT index is `Inst[3:0]`.

Ports:
- `Clk`  in  1: clock, all state changes on posedge.
- `Reset`  in  1: synchronous, active-high.
- `Start`  in  1: host load/hold; high freezes `ProgCtr`; shared with `ProgCtr`.
- `PcIn`  in  L: current `ProgCtr` value (ROM address).
- `InstIn`  in  W: ROM data at `PcIn`.
- `ALUFlag`  in  1: branch condition; same signal `ProgCtr` sees.
- `LutWe`  in  1: LUT write enable (honoured only while `Start`=1).
- `LutAddr`  in  4: LUT write index.
- `LutData`  in  L: signed relative offset, measured from the branch instruction's own address.
- `Inst`  out  W: issued instruction register.
- `InstPc`  out  L: address of `Inst`.
- `InstValid`  out  1: `Inst` is live; the decoder ignores it when 0.
- `BranchRel`  out  1: to `ProgCtr`; combinational.
- `Target`  out  L: to `ProgCtr`; combinational.
- `Done`  out  1: program halted; sticky.

## Operation
Decode (combinational, from registers):
- `isBr = InstValid && Inst[W-1:W-4]==4'b1111`
- `isHalt = InstValid && Inst[W-1:W-4]==4'b1110`
- `BranchRel = isBr`
- `Target = Lut[Inst[3:0]] - 1`, mod 2^L. The -1 compensates because `ProgCtr` already holds `InstPc+1`.
- `taken = isBr && ALUFlag`

Register update priority, first match wins:
1. `Reset`: `Inst`=0, `InstPc`=0, `InstValid`=0, `Done`=0, all 16 LUT entries=0.
2. `Start`: `InstValid`=0, `Done`=0. If `LutWe`, then `Lut[LutAddr]<=LutData`.
3. `Done`: hold everything; `InstValid`=0.
4. `isHalt`: `Done`<=1, `InstValid`<=0. The word fetched behind the halt is discarded.
5. `taken`: `InstValid`<=0. This is the bubble; the wrong-path word at `InstPc+1` is dropped.
6. Otherwise: `Inst`<=`InstIn`, `InstPc`<=`PcIn`, `InstValid`<=1.

Other rules:
- `LutWe` with `Start`=0 is ignored. The LUT is never written by `Reset`=0 traffic outside `Start`.
- A not-taken branch (`isBr` and `ALUFlag`=0) issues normally; no bubble.
- The `Target` subtraction wraps mod 2^L, e.g. offset 0 gives 2^L-1, which re-executes the branch.
- `Start` asserted mid-program kills the issued instruction next edge and clears `Done`.
- `Reset` mid-program wins over everything, including a pending taken branch.

## Timing
- Fetch-to-issue latency: 1 cycle. Steady state: `PcIn` = `InstPc`+1 while `InstValid`=1.
- First issue: on the first edge with `Start`=0 after `Start`/`Reset`, the word at PC 0 is captured. `InstValid`=1 from the next cycle.
- Taken branch at `InstPc`=p with offset o:
  - At that edge `ProgCtr` loads p+o; `InstValid` goes 0 for exactly one cycle.
  - The next edge captures the word at p+o.
  - Branch penalty is 1 cycle.
- Halt issued in cycle n: `Done`=1 from cycle n+1 and holds until `Start` or `Reset`. `ProgCtr` may keep counting; that is harmless.
- `BranchRel`/`Target` are valid in the same cycle `Inst` is; there is no extra register stage.

## Test plan
(L=10, W=9)
- Reset: pulse `Reset`, then ROM[0]=9'h005 -> after reset, `Inst`=0 and `InstValid`=0; one edge later `Inst`=9'h005, `InstPc`=0, `InstValid`=1.
- LUT load and gating:
  - `Start`=1, write `Lut[3]`=10'd4, then `Start`=0; ROM[0]=9'h1E3 (branch, index 3), `ALUFlag`=1 -> `BranchRel`=1, `Target`=3; PC goes to 4; one bubble; `Inst`=ROM[4] with `InstPc`=4.
  - `LutWe` with `Start`=0 leaves the LUT unchanged.
- Not-taken branch: same program with `ALUFlag`=0 -> no bubble; `InstPc` sequence 0,1,2 on consecutive cycles.
- Backward branch and wrap:
  - `Lut[1]`=10'h3FE (-2), branch at PC 5 -> `Target`=10'h3FD; next issued `InstPc`=3.
  - `Lut[2]`=0 -> `Target`=10'h3FF; the branch re-issues itself.
- Halt:
  - ROM[2]=9'h1C0 -> `Done`=1 one cycle after it issues; `InstValid` stays 0; `Done` holds.
  - Raising `Start` clears `Done` next edge.
- Reset priority: assert `Reset` in the same cycle as a taken branch -> all outputs zero next edge; LUT reads 0.
